// File: rtl/vga_pkg.sv
// Shared VGA timing constants and types: 640x480@60 defaults, 8-bit colour, 12-bit coordinates.
// No logic here; consumed by the axis counters and the timing top.
package vga_pkg;

  localparam int COLOR_W = 8;
  localparam int COORD_W = 12;

  localparam int H_VIS_DEF  = 640;
  localparam int H_FP_DEF   = 16;
  localparam int H_SYNC_DEF = 96;
  localparam int H_BP_DEF   = 48;

  localparam int V_VIS_DEF  = 480;
  localparam int V_FP_DEF   = 10;
  localparam int V_SYNC_DEF = 2;
  localparam int V_BP_DEF   = 33;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [COLOR_W-1:0] color_t;

  function automatic int axis_total(input int vis, input int fp, input int sync, input int bp);
    return vis + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter plus visible/sync decodes; advances on adv, zero latency.
// No backpressure; holds whenever adv is low.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int VIS  = H_VIS_DEF,
  parameter int FP   = H_FP_DEF,
  parameter int SYNC = H_SYNC_DEF,
  parameter int BP   = H_BP_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               adv,
  output logic [COORD_W-1:0] count,
  output logic               wrap,
  output logic               visible,
  output logic               sync_active
);

  localparam int     TOTAL   = axis_total(VIS, FP, SYNC, BP);
  localparam coord_t LAST    = coord_t'(TOTAL - 1);
  localparam coord_t VIS_END = coord_t'(VIS);
  localparam coord_t SYNC_LO = coord_t'(VIS + FP);
  localparam coord_t SYNC_HI = coord_t'(VIS + FP + SYNC - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (adv) begin
      count <= wrap ? '0 : count + coord_t'(1);
    end
  end

  assign wrap        = (count == LAST);
  assign visible     = (count < VIS_END);
  assign sync_active = (count >= SYNC_LO) && (count <= SYNC_HI);

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing: raw x/y counters plus registered sync, DE and blank-gated colour; 1 pix_en tick latency.
// No backpressure; everything holds while pix_en is low (frame_start drops to 0).
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_VIS    = H_VIS_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_VIS    = V_VIS_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pix_en,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  input  logic [COLOR_W-1:0] rgb_r_in,
  input  logic [COLOR_W-1:0] rgb_g_in,
  input  logic [COLOR_W-1:0] rgb_b_in,
  output logic               vga_hs,
  output logic               vga_vs,
  output logic               vga_de,
  output logic [COLOR_W-1:0] vga_r,
  output logic [COLOR_W-1:0] vga_g,
  output logic [COLOR_W-1:0] vga_b,
  output logic               frame_start
);

  logic h_wrap, h_vis, h_sync;
  logic v_wrap, v_vis, v_sync;
  logic visible;

  vga_axis_counter #(
    .VIS (H_VIS),
    .FP  (H_FP),
    .SYNC(H_SYNC),
    .BP  (H_BP)
  ) u_h_axis (
    .clk        (clk),
    .rst_n      (rst_n),
    .adv        (pix_en),
    .count      (x),
    .wrap       (h_wrap),
    .visible    (h_vis),
    .sync_active(h_sync)
  );

  // Vertical steps once per line, on the tick that wraps the horizontal counter.
  vga_axis_counter #(
    .VIS (V_VIS),
    .FP  (V_FP),
    .SYNC(V_SYNC),
    .BP  (V_BP)
  ) u_v_axis (
    .clk        (clk),
    .rst_n      (rst_n),
    .adv        (pix_en & h_wrap),
    .count      (y),
    .wrap       (v_wrap),
    .visible    (v_vis),
    .sync_active(v_sync)
  );

  assign visible = h_vis & v_vis;

  // Output stage samples the pre-increment position, so outputs trail x/y by one tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_hs      <= ~SYNC_POL;
      vga_vs      <= ~SYNC_POL;
      vga_de      <= 1'b0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_en & h_wrap & v_wrap;
      if (pix_en) begin
        vga_hs <= h_sync ? SYNC_POL : ~SYNC_POL;
        vga_vs <= v_sync ? SYNC_POL : ~SYNC_POL;
        vga_de <= visible;
        vga_r  <= visible ? rgb_r_in : '0;
        vga_g  <= visible ? rgb_g_in : '0;
        vga_b  <= visible ? rgb_b_in : '0;
      end
    end
  end

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 SHALL have parameter H_VIS, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-004 SHALL have parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 SHALL have parameter V_VIS, default 480, visible lines per frame.
REQ-006 SHALL have parameter V_FP, default 10, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 2, vertical sync width in lines.
REQ-008 SHALL have parameter V_BP, default 33, vertical back porch in lines.
REQ-009 SHALL have parameter SYNC_POL, default 0, active sync level (0 = active-low).
REQ-010 SHALL use one clock and an asynchronous, active-low reset:
- clk  in  1  system clock
- rst_n  in  1  async active-low reset
REQ-011 SHALL have the remaining ports:
- pix_en  in  1  pixel tick enable; all state advances only when high
- x  out  12  raw horizontal counter, 0..H_TOTAL-1
- y  out  12  raw vertical counter, 0..V_TOTAL-1
- rgb_r_in / rgb_g_in / rgb_b_in  in  8 each  colour from downstream renderer for the current x,y
- vga_hs  out  1  registered horizontal sync
- vga_vs  out  1  registered vertical sync
- vga_de  out  1  registered display enable
- vga_r / vga_g / vga_b  out  8 each  registered, blank-gated colour
- frame_start  out  1  one-clk pulse marking entry to (0,0)

Function
REQ-012 H_TOTAL SHALL equal H_VIS+H_FP+H_SYNC+H_BP (800); V_TOTAL SHALL equal V_VIS+V_FP+V_SYNC+V_BP (525).
REQ-013 On a clk edge with pix_en=1, x SHALL increment; at x=H_TOTAL-1 it SHALL wrap to 0 and y SHALL increment.
REQ-014 At x=H_TOTAL-1 and y=V_TOTAL-1, both counters SHALL wrap to 0 on the same tick.
REQ-015 With pix_en=0, counters and all registered outputs SHALL hold, except frame_start, which SHALL be 0.
REQ-016 x and y SHALL be driven directly from the counter registers, with zero latency.
REQ-017 Visible region SHALL be x<H_VIS and y<V_VIS; hsync region x in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC-1] (656..751); vsync region y in [V_VIS+V_FP, V_VIS+V_FP+V_SYNC-1] (490..491).
REQ-018 On each pix_en tick, the output stage SHALL sample the pre-increment counter values and rgb_*_in.
- vga_hs/vga_vs = SYNC_POL inside their sync region, else ~SYNC_POL
- vga_de = visible
- vga_r/g/b = rgb_*_in when visible, else 0
REQ-019 Latency SHALL be exactly one pix_en tick from a given x,y to its sync, de and colour outputs.
REQ-020 frame_start SHALL be 1 for exactly one clk, on the clk after the tick that wraps both counters to (0,0).

Reset
REQ-021 While rst_n=0, outputs SHALL take these values immediately, without waiting for a clk edge:
- x=0, y=0
- vga_hs=vga_vs=~SYNC_POL
- vga_de=0, vga_r/g/b=0, frame_start=0
REQ-022 After rst_n deasserts, the first pix_en tick SHALL process (0,0), and no frame_start SHALL occur until the first full wrap.
REQ-023 Reset asserted mid-frame SHALL abandon the frame; no partial sync pulse SHALL be stretched or completed.

Structure
REQ-024 A shared package vga_pkg SHALL hold the default timing constants, the colour width (8) and the coordinate width (12).
REQ-025 A sub-module vga_axis_counter (parameters VIS, FP, SYNC, BP) SHALL be instantiated twice, for H and V.
- ports: count, wrap, visible, sync_active
- the V instance SHALL advance on the H instance's wrap qualified by pix_en
REQ-026 The output register stage SHALL live in vga_timing.

Verification
REQ-027 Reset, then pix_en=1 for 800 clks -> x=0, y=1; no frame_start.
REQ-028 pix_en=1 continuously -> vga_hs low for exactly 96 consecutive clks, first low clk being the one after x=656 is sampled.
REQ-029 420000 clks with pix_en=1 -> exactly one frame_start pulse; vga_vs low for exactly 1600 clks; vga_de high for 307200 clks.
REQ-030 rgb_in held at 255/0/0 -> vga_r=255 only while vga_de=1; vga_r=0 at the output tick for x=640.
REQ-031 pix_en toggling every other clk -> counters advance at half rate; outputs unchanged on pix_en=0 clks; 800 pix_en ticks per line.
REQ-032 rst_n pulsed low at x=300, y=200 -> outputs reach reset values before the next clk edge; after release, counting resumes from (0,0).
